// File: rtl/packer_pkg.sv
// Shared constants and FSM state type for the packet buffer.
package packer_pkg;

   localparam int PB_DEPTH_DEFAULT = 16;
   localparam int PB_WIDTH         = 8;

   typedef enum logic [1:0] {
      PB_IDLE   = 2'd0,
      PB_ACTIVE = 2'd1,
      PB_DRAIN  = 2'd2,
      PB_DONE   = 2'd3
   } pb_state_t;

endpackage

// File: rtl/packet_buffer_if.sv
// Producer/consumer bundle of the packet buffer. byte_count exists only
// when PACKET_BUFFER_COUNT_EN is defined.
interface packet_buffer_if;
   import packer_pkg::*;

   logic [PB_WIDTH-1:0] pkt_data;
   logic                packet_done;
   logic                last_packet;
   logic                clear;
   logic [PB_WIDTH-1:0] out_data;
   logic                out_last;
   logic                out_valid;
   logic                out_ready;
   logic                full;
   logic                overflow;
   logic                msg_done;
`ifdef PACKET_BUFFER_COUNT_EN
   logic [15:0]         byte_count;

   modport master (
      output pkt_data, packet_done, last_packet, clear, out_ready,
      input  out_data, out_last, out_valid, full, overflow, msg_done, byte_count
   );
   modport slave (
      input  pkt_data, packet_done, last_packet, clear, out_ready,
      output out_data, out_last, out_valid, full, overflow, msg_done, byte_count
   );
`else
   modport master (
      output pkt_data, packet_done, last_packet, clear, out_ready,
      input  out_data, out_last, out_valid, full, overflow, msg_done
   );
   modport slave (
      input  pkt_data, packet_done, last_packet, clear, out_ready,
      output out_data, out_last, out_valid, full, overflow, msg_done
   );
`endif

endinterface

// File: rtl/pb_fifo_mem.sv
// Packet buffer storage: DEPTH x {last, data} register array, one write
// port, asynchronous read. Contents are deliberately not reset.
module pb_fifo_mem
   import packer_pkg::*;
#(
   parameter int DEPTH = PB_DEPTH_DEFAULT,
   parameter int WIDTH = PB_WIDTH + 1
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_buffer.sv
// Message-aware byte FIFO between the packer and its consumer.
// Define PACKET_BUFFER_COUNT_EN to add the byte_count output.
//
// state  | meaning
// IDLE   | no message in progress
// ACTIVE | message bytes arriving, final byte not yet seen
// DRAIN  | final byte stored; new bytes dropped until it is read out
// DONE   | final byte transferred; msg_done high for this one cycle
module packet_buffer
   import packer_pkg::*;
#(
   parameter int DEPTH = PB_DEPTH_DEFAULT
) (
   input  logic            clk,
   input  logic            n_rst,
   packet_buffer_if.slave  pb_io
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   pb_state_t         state_q, state_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic [PB_WIDTH:0] head;
   logic              full, rd_en, wr_en, drop_en;

   assign full  = (count_q == CNT_FULL);
   assign rd_en = (count_q != '0) && pb_io.out_ready;
   // A full buffer can still take a byte when the head leaves in the same cycle.
   assign wr_en   = pb_io.packet_done && (state_q != PB_DRAIN) && (!full || rd_en);
   assign drop_en = pb_io.packet_done && !wr_en;

   pb_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (PB_WIDTH + 1)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_en && !pb_io.clear),
      .waddr_i (wr_ptr_q),
      .wdata_i ({pb_io.last_packet, pb_io.pkt_data}),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
   );

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | drop_en;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (pb_io.clear) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PB_IDLE, PB_DONE: begin
            if (wr_en)                 state_d = pb_io.last_packet ? PB_DRAIN : PB_ACTIVE;
            else if (state_q == PB_DONE) state_d = PB_IDLE;
         end
         PB_ACTIVE: if (wr_en && pb_io.last_packet) state_d = PB_DRAIN;
         PB_DRAIN:  if (rd_en && head[PB_WIDTH])    state_d = PB_DONE;
         default:   state_d = PB_IDLE;
      endcase
      if (pb_io.clear) state_d = PB_IDLE;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= PB_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign pb_io.out_data  = head[PB_WIDTH-1:0];
   assign pb_io.out_last  = head[PB_WIDTH];
   assign pb_io.out_valid = (count_q != '0);
   assign pb_io.full      = full;
   assign pb_io.overflow  = overflow_q;
   assign pb_io.msg_done  = (state_q == PB_DONE);

`ifdef PACKET_BUFFER_COUNT_EN
   logic [15:0] byte_count_q, byte_count_d;

   always_comb begin
      byte_count_d = byte_count_q;
      if (pb_io.clear || state_q == PB_DONE) byte_count_d = '0;
      else if (rd_en && byte_count_q != 16'hFFFF) byte_count_d = byte_count_q + 16'd1;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) byte_count_q <= '0;
      else        byte_count_q <= byte_count_d;
   end

   assign pb_io.byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_packet_buffer.sv
// Self-checking bench for packet_buffer (DEPTH=16) with a read-order scoreboard.
module tb_packet_buffer;
   import packer_pkg::*;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   logic [8:0] exp_q [$];

   packet_buffer_if bus ();

   packet_buffer dut (
      .clk   (clk),
      .n_rst (n_rst),
      .pb_io (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.pkt_data    = 8'h00;
      bus.packet_done = 1'b0;
      bus.last_packet = 1'b0;
      bus.clear       = 1'b0;
      bus.out_ready   = 1'b0;
   endtask

   // One clock cycle; acc = bench expects the write to be stored.
   task automatic step(input logic pd, input logic lst, input logic [7:0] d,
                       input logic rdy, input logic acc, input logic clr);
      logic [8:0] e;
      bus.packet_done = pd;
      bus.last_packet = lst;
      bus.pkt_data    = d;
      bus.out_ready   = rdy;
      bus.clear       = clr;
      #1;
      if (bus.out_valid === 1'b1 && rdy && !clr) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL read_unexpected: got %h, expected no transfer", {bus.out_last, bus.out_data});
         end else begin
            e = exp_q.pop_front();
            if ({bus.out_last, bus.out_data} !== e) begin
               n_fail++;
               $display("FAIL read_data: got %h, expected %h", {bus.out_last, bus.out_data}, e);
            end
         end
      end
      if (pd && acc && !clr) exp_q.push_back({lst, d});
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      n_rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b, expected 0", bus.out_valid); end
      n_checks++; if (bus.full !== 1'b0)      begin n_fail++; $display("FAIL rst_full: got %b, expected 0", bus.full); end
      n_checks++; if (bus.overflow !== 1'b0)  begin n_fail++; $display("FAIL rst_overflow: got %b, expected 0", bus.overflow); end
      n_checks++; if (bus.msg_done !== 1'b0)  begin n_fail++; $display("FAIL rst_msg_done: got %b, expected 0", bus.msg_done); end
      n_rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      bus.packet_done = 1'b1;
      bus.last_packet = 1'b0;
      bus.pkt_data    = 8'hA5;
      bus.out_ready   = 1'b1;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL same_cycle_valid: got %b, expected 0", bus.out_valid); end
      exp_q.push_back({1'b0, 8'hA5});
      @(posedge clk);
      #1;
      n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: got %b, expected 1", bus.out_valid); end
      step(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done: got %b, expected 0", bus.msg_done); end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b1) begin n_fail++; $display("FAIL basic_msg_done: got %b, expected 1", bus.msg_done); end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b, expected 0", bus.msg_done); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b, expected 0", bus.out_valid); end
   endtask

   task automatic test_full_overflow();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 1'b0, 8'(i * 3 + 1), 1'b0, (i < 16), 1'b0);
         if (i == 14) begin
            n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL full_at_15: got %b, expected 0", bus.full); end
         end
         if (i == 15) begin
            n_checks++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL full_at_16: got %b, expected 1", bus.full); end
            n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_16: got %b, expected 0", bus.overflow); end
         end
      end
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_17: got %b, expected 1", bus.overflow); end
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b, expected 0", bus.out_valid); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_missing_reads: got %0d left, expected 0", exp_q.size()); end
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b, expected 1", bus.overflow); end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0);
      n_checks++; if (bus.full !== 1'b1)     begin n_fail++; $display("FAIL rw_full: got %b, expected 1", bus.full); end
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rw_overflow: got %b, expected 0", bus.overflow); end
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rw_drained: got %b, expected 0", bus.out_valid); end
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rw_missing_reads: got %0d left, expected 0", exp_q.size()); end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_drain_drop();
      step(1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0);
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL drain_overflow: got %b, expected 1", bus.overflow); end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b1) begin n_fail++; $display("FAIL drain_msg_done: got %b, expected 1", bus.msg_done); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_dropped: got %b, expected 0", bus.out_valid); end
   endtask

   task automatic test_clear();
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b1);
      exp_q.delete();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b, expected 0", bus.out_valid); end
      n_checks++; if (bus.overflow !== 1'b0)  begin n_fail++; $display("FAIL clr_overflow: got %b, expected 0", bus.overflow); end
      n_checks++; if (bus.msg_done !== 1'b0)  begin n_fail++; $display("FAIL clr_msg_done: got %b, expected 0", bus.msg_done); end
      step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b1) begin n_fail++; $display("FAIL clr_new_msg_done: got %b, expected 1", bus.msg_done); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h90 + i), 1'b0, 1'b1, 1'b0);
      n_rst = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b, expected 0", bus.out_valid); end
      exp_q.delete();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      step(1'b1, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b1) begin n_fail++; $display("FAIL post_rst_msg_done: got %b, expected 1", bus.msg_done); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_empty: got %b, expected 0", bus.out_valid); end
   endtask

`ifdef PACKET_BUFFER_COUNT_EN
   task automatic test_byte_count();
      for (int i = 0; i < 20; i++) step(1'b1, (i == 19), 8'(8'h10 + i), 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.msg_done !== 1'b1) begin n_fail++; $display("FAIL cnt_msg_done: got %b, expected 1", bus.msg_done); end
      n_checks++; if (bus.byte_count !== 16'd20) begin n_fail++; $display("FAIL cnt_value: got %0d, expected 20", bus.byte_count); end
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_checks++; if (bus.byte_count !== 16'd0) begin n_fail++; $display("FAIL cnt_zeroed: got %0d, expected 0", bus.byte_count); end
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_full_overflow();
      test_full_rw();
      test_drain_drop();
      test_clear();
      test_reset_mid();
`ifdef PACKET_BUFFER_COUNT_EN
      test_byte_count();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
